// File: rtl/stream_argmin_if.sv
// Stream handshake and result bundle for stream_argmin.
// The master side feeds elements and start; the slave side is the argmin block.
interface stream_argmin_if #(
    parameter int N = 8,
    parameter int L = 3
);
    logic              start;
    logic              in_valid;
    logic [N-1:0]      in_data;
    logic              in_ready;
    logic              done;
    logic [N-1:0]      min_val;
    logic [L-1:0]      min_idx;
    logic [2**L-1:0]   min_onehot;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, done, min_val, min_idx, min_onehot
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, done, min_val, min_idx, min_onehot
    );
endinterface

// File: rtl/stream_argmin.sv
// Streaming argmin over a run of 2**L unsigned elements.
// Define STREAM_ARGMIN_TIE_LAST_EN to let the latest of equal minima win (default: earliest).
module stream_argmin #(
    parameter int N = 8,
    parameter int L = 3
) (
    input  logic             clk,
    input  logic             rst,
    stream_argmin_if.slave   bus
);
    // state | meaning
    // IDLE  | waiting for start after reset
    // RUN   | accepting elements, tracking running minimum
    // DONE  | result valid and held until the next start
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [L:0] LAST = {1'b0, {L{1'b1}}};

    logic [1:0]   state;
    logic [L:0]   cnt;
    logic [N-1:0] min_val_r;
    logic [L-1:0] min_idx_r;
    logic         done_r;
    logic         better;

`ifdef STREAM_ARGMIN_TIE_LAST_EN
    assign better = (bus.in_data <= min_val_r);
`else
    assign better = (bus.in_data < min_val_r);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            min_val_r <= '0;
            min_idx_r <= '0;
            done_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (bus.in_valid) begin
                        // first element of a run seeds the minimum unconditionally
                        if (cnt == '0 || better) begin
                            min_val_r <= bus.in_data;
                            min_idx_r <= cnt[L-1:0];
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        done_r <= 1'b0;
                        cnt    <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state == RUN);
    assign bus.done       = done_r;
    assign bus.min_val    = min_val_r;
    assign bus.min_idx    = min_idx_r;
    assign bus.min_onehot = {{(2**L-1){1'b0}}, 1'b1} << min_idx_r;
endmodule

// File: tb/tb_stream_argmin.sv
// Randomized self-checking bench for stream_argmin against a queue-based argmin model.
module tb_stream_argmin;
    localparam int N = 8;
    localparam int L = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    stream_argmin_if #(.N(N), .L(L)) bus ();
    stream_argmin #(.N(N), .L(L)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // minimum value first, then pick the earliest or latest position holding it
    function automatic void ref_argmin(input int vals[$], output int mv, output int mi);
        mv = vals[0];
        foreach (vals[i]) if (vals[i] < mv) mv = vals[i];
        mi = -1;
        foreach (vals[i]) begin
            if (vals[i] == mv) begin
`ifdef STREAM_ARGMIN_TIE_LAST_EN
                mi = i;
`else
                if (mi < 0) mi = i;
`endif
            end
        end
    endfunction

    // seq entries < 0 are bubble cycles; poke drives random start during bubbles
    task automatic do_run(input string name, input int seq[$], input bit with_start, input bit poke);
        int acc[$];
        int mv, mi;
        if (with_start) begin
            @(negedge clk); bus.start = 1'b1;
            @(negedge clk); bus.start = 1'b0;
        end
        foreach (seq[i]) begin
            @(negedge clk);
            check({name, "_ready"}, 32'(bus.in_ready), 1);
            check({name, "_early_done"}, 32'(bus.done), 0);
            if (seq[i] < 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = N'($urandom_range(0, 255));
                bus.start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = N'(seq[i]);
                bus.start    = 1'b0;
                acc.push_back(seq[i]);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        ref_argmin(acc, mv, mi);
        check({name, "_done"}, 32'(bus.done), 1);
        check({name, "_ready_off"}, 32'(bus.in_ready), 0);
        check({name, "_val"}, 32'(bus.min_val), mv);
        check({name, "_idx"}, 32'(bus.min_idx), mi);
        check({name, "_onehot"}, 32'(bus.min_onehot), 32'(1) << mi);
    endtask

    initial begin
        int q[$];
        int v;
        rst = 1'b0;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_done", 32'(bus.done), 0);
        check("rst_ready", 32'(bus.in_ready), 0);
        check("rst_val", 32'(bus.min_val), 0);
        check("rst_idx", 32'(bus.min_idx), 0);
        check("rst_onehot", 32'(bus.min_onehot), 1);
        @(negedge clk); @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(bus.in_ready), 0);
        check("idle_done", 32'(bus.done), 0);

        q = '{9, 4, 7, 2};
        do_run("r9472", q, 1'b1, 1'b0);
        check("r9472_onehot_lit", 32'(bus.min_onehot), 32'h8);

        // DONE holds regardless of in_valid
        repeat (4) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.in_data  = '0;
            check("hold_val", 32'(bus.min_val), 2);
            check("hold_idx", 32'(bus.min_idx), 3);
            check("hold_done", 32'(bus.done), 1);
            check("hold_ready", 32'(bus.in_ready), 0);
        end
        @(negedge clk); bus.in_valid = 1'b0; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        check("restart_done", 32'(bus.done), 0);
        check("restart_ready", 32'(bus.in_ready), 1);
        q = '{255, 255, 255, 255};
        do_run("r255", q, 1'b0, 1'b0);

        q = '{5, 3, 3, 8};
        do_run("r5338", q, 1'b1, 1'b0);

        q = '{200, -1, -1, 10, -1, 150, 255};
        do_run("rbub", q, 1'b1, 1'b0);

        // reset in the middle of a run
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'd6;
        @(negedge clk); bus.in_data = 8'd1;
        @(negedge clk); bus.in_valid = 1'b0;
        check("mid_val_pre", 32'(bus.min_val), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_val", 32'(bus.min_val), 0);
        check("mid_rst_idx", 32'(bus.min_idx), 0);
        check("mid_rst_onehot", 32'(bus.min_onehot), 1);
        check("mid_rst_done", 32'(bus.done), 0);
        check("mid_rst_ready", 32'(bus.in_ready), 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_ready", 32'(bus.in_ready), 0);
        check("post_rst_done", 32'(bus.done), 0);
        q = '{0, 0, 0, 0};
        do_run("rzero", q, 1'b1, 1'b0);

        for (int r = 0; r < 20; r++) begin
            q.delete();
            for (int e = 0; e < 2**L; e++) begin
                v = $urandom_range(0, 2);
                for (int b = 0; b < v; b++) q.push_back(-1);
                q.push_back((r % 2 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255));
            end
            do_run($sformatf("rand%0d", r), q, 1'b1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
